param_cacheline_adapter: RTL and testbench
==========================================

Name: param_cacheline_adapter

Overview:
- Downstream neighbour of the parameterised cache datapath/control pair.
- Converts one full-line physical-memory request from the cache into a fixed-length burst on a narrow memory bus:
  - A read assembles Beats incoming beats into one line.
  - A write splits the latched line into Beats outgoing beats.
- Returns a single-cycle completion pulse to the cache.

Parameters:
- LineWidth, 256, cache line width in bits; must equal Beats*BeatWidth.
- BeatWidth, 64, memory bus data width per beat.
- Beats, LineWidth/BeatWidth (4), beats per burst; must be a power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- line_i  input  LineWidth  line to write back; sampled at write accept.
- line_o  output  LineWidth  assembled read line.
- address_i  input  32  line address from the cache.
- read_i  input  1  cache line-read request, level.
- write_i  input  1  cache line-write request, level.
- resp_o  output  1  one-cycle completion pulse to the cache.
- burst_i  input  BeatWidth  read beat from memory.
- burst_o  output  BeatWidth  write beat to memory.
- address_o  output  32  line-aligned burst address.
- read_o  output  1  burst read request to memory.
- write_o  output  1  burst write request to memory.
- resp_i  input  1  memory beat acknowledge; one beat per high cycle.

Behaviour:
- Reset (rst low, asynchronous; release synchronous to clk):
  - state=IDLE, beat counter=0, resp_o=0, read_o=0, write_o=0.
  - address_o=0, burst_o=0, line_o=0, internal line buffer=0.
  - Reset mid-burst abandons the burst immediately; no resp_o is produced.
- State machine: IDLE, RD, WR, DONE.
- IDLE:
  - write_i=1: latch line_i into the buffer, latch address_i with bits [$clog2(LineWidth/8)-1:0] cleared, counter=0, go to WR.
  - else read_i=1: latch the aligned address, counter=0, go to RD.
  - write_i and read_i both high: write wins; the read is ignored and must be held or reasserted by the cache.
  - resp_i in IDLE is ignored.
- RD:
  - read_o=1 and address_o=latched address throughout.
  - Each cycle with resp_i=1: buffer[counter*BeatWidth +: BeatWidth] <= burst_i, counter increments.
  - On the cycle resp_i accepts beat Beats-1: counter wraps to 0, go to DONE. read_o drops in the DONE cycle.
  - Cycles with resp_i=0 are stalls; no state change.
- WR:
  - write_o=1, address_o=latched address.
  - burst_o=buffer[counter*BeatWidth +: BeatWidth], combinational from the counter.
  - Each resp_i=1 advances the counter; after beat Beats-1, go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0; then IDLE unconditionally.
  - line_o reflects the buffer in the DONE cycle and holds until the next read completes.
  - Write bursts do not change line_o.
- Request level: the cache holds read_i/write_i until it sees resp_o and deasserts them in the cycle after resp_o. A request visible in that IDLE cycle is accepted as a new transaction.
- Requests arriving in RD, WR or DONE are ignored; address_i and line_i changes after accept have no effect.
- Latency:
  - Accept at edge 0; read_o/write_o high from cycle 1.
  - If resp_i is high on cycles k..k+Beats-1, resp_o is high on cycle k+Beats.
  - Minimum request-to-resp_o: Beats+2 cycles.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high, no requests → all outputs 0 for 10 cycles; resp_i pulses ignored.
- Back-to-back read:
  - Stimulus: read_i=1, address_i=0x1234_567F; resp_i high 4 consecutive cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: address_o=0x1234_5660; one resp_o pulse the next cycle; line_o=0x44..44_33..33_22..22_11..11 (beat 0 in the LSBs).
- Stalled write:
  - Stimulus: write_i=1, line_i=0xDDDD..CCCC..BBBB..AAAA, address_i=0x8000_0020; resp_i pattern 1,0,0,1,1,0,1.
  - Response: burst_o steps AAAA→BBBB→CCCC→DDDD only on acked cycles; resp_o one cycle after the 4th ack; line_o unchanged.
- Simultaneous request: read_i=write_i=1 in IDLE → write_o asserted, read_o stays 0; read serviced after resp_o only if read_i is still held.
- Reset mid-burst:
  - Stimulus: read started, 2 beats acked, rst pulsed low mid-cycle.
  - Response: read_o, resp_o and line_o go to 0 immediately without a clock edge; the next read takes a full 4 beats.
- Ignored mid-burst request: write_i asserted while in RD with address_i changed → address_o stays at the read address; write starts only in IDLE after resp_o.

Source files
------------

// File: rtl/param_cacheline_adapter.sv
// Purpose: converts one full-line read/write request from the cache into a Beats-long burst on a narrow memory bus.
// Latency: accept at edge 0, burst request from cycle 1, resp_o one cycle after the last beat ack (min Beats+2 cycles).
// Backpressure: memory paces beats with resp_i (low = stall); cache requests are level-held until resp_o.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   line_i / line_o      write-back line in (sampled at accept) / assembled read line out
//   address_i            line address from the cache; offset bits are cleared on accept
//   read_i / write_i     cache line requests (level); write wins when both are high in IDLE
//   resp_o               one-cycle completion pulse to the cache
//   burst_i / burst_o    read beat from memory / write beat to memory
//   address_o            line-aligned burst address
//   read_o / write_o     burst requests to memory, high for the whole burst
//   resp_i               memory beat acknowledge, one beat per high cycle
module param_cacheline_adapter #(
  parameter int LineWidth = 256,
  parameter int BeatWidth = 64,
  parameter int Beats     = LineWidth / BeatWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LineWidth-1:0] line_i,
  output logic [LineWidth-1:0] line_o,
  input  logic [31:0]          address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [BeatWidth-1:0] burst_i,
  output logic [BeatWidth-1:0] burst_o,
  output logic [31:0]          address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i
);

  localparam int              CntW      = $clog2(Beats);
  localparam int              OffW      = $clog2(LineWidth / 8);
  localparam logic [31:0]     AlignMask = ~((32'd1 << OffW) - 32'd1);
  localparam logic [CntW-1:0] LastBeat  = CntW'(Beats - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [31:0]                     addr_q, addr_d;
  // Beat-indexed view of the line buffer: beat 0 sits in the LSBs.
  logic [Beats-1:0][BeatWidth-1:0] buf_q, buf_d;
  // Separate copy of the last completed read so write bursts never disturb line_o.
  logic [LineWidth-1:0]            line_q, line_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          buf_d   = line_i;
          addr_d  = address_i & AlignMask;
          cnt_d   = '0;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = address_i & AlignMask;
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          buf_d[cnt_q] = burst_i;
          // Counter wraps to 0 after the last beat since Beats is a power of two.
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            // Capture the line including the final beat so line_o is valid in DONE.
            line_d  = buf_d;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
    end
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign burst_o   = buf_q[cnt_q];
  assign line_o    = line_q;

endmodule

// File: tb/tb_param_cacheline_adapter.sv
module tb_param_cacheline_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic [31:0]   address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic          resp_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic [31:0]   address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  param_cacheline_adapter #(.LineWidth(LW), .BeatWidth(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic                   m_busy     = 1'b0;  // burst in flight
  logic                   m_is_write = 1'b0;
  logic                   m_resp_due = 1'b0;  // completion being signalled
  logic                   m_fresh    = 1'b1;  // nothing accepted since reset
  int                     m_beat     = 0;     // beats acked so far in this burst
  logic [31:0]            m_addr     = '0;
  logic [NB-1:0][BW-1:0]  m_buf      = '0;
  logic [LW-1:0]          m_line     = '0;

  function automatic logic [LW-1:0] with_beat(input logic [LW-1:0] l, input int idx,
                                               input logic [BW-1:0] v);
    logic [NB-1:0][BW-1:0] t;
    t      = l;
    t[idx] = v;
    return t;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~(32'(LW / 8) - 32'd1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_is_write <= 1'b0; m_resp_due <= 1'b0; m_fresh <= 1'b1;
      m_beat <= 0; m_addr <= '0; m_buf <= '0; m_line <= '0;
    end else if (m_resp_due) begin
      m_resp_due <= 1'b0;
    end else if (m_busy) begin
      if (resp_i) begin
        if (!m_is_write) m_buf <= with_beat(m_buf, m_beat, burst_i);
        if (m_beat == NB - 1) begin
          m_busy     <= 1'b0;
          m_resp_due <= 1'b1;
          m_beat     <= 0;
          if (!m_is_write) m_line <= with_beat(m_buf, m_beat, burst_i);
        end else begin
          m_beat <= m_beat + 1;
        end
      end
    end else if (write_i) begin
      m_busy <= 1'b1; m_is_write <= 1'b1; m_buf <= line_i;
      m_addr <= align(address_i); m_beat <= 0; m_fresh <= 1'b0;
    end else if (read_i) begin
      m_busy <= 1'b1; m_is_write <= 1'b0;
      m_addr <= align(address_i); m_beat <= 0; m_fresh <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_read_o",  LW'(read_o),    '0);
      chk("rst_write_o", LW'(write_o),   '0);
      chk("rst_resp_o",  LW'(resp_o),    '0);
      chk("rst_addr_o",  LW'(address_o), '0);
      chk("rst_burst_o", LW'(burst_o),   '0);
      chk("rst_line_o",  line_o,         '0);
    end else begin
      chk("read_o",  LW'(read_o),  LW'(m_busy && !m_is_write));
      chk("write_o", LW'(write_o), LW'(m_busy && m_is_write));
      chk("resp_o",  LW'(resp_o),  LW'(m_resp_due));
      chk("line_o",  line_o,       m_line);
      if (m_busy || m_fresh) chk("address_o", LW'(address_o), LW'(m_addr));
      if ((m_busy && m_is_write) || m_fresh) chk("burst_o", LW'(burst_o), LW'(m_buf[m_beat]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [LW-1:0] rd_line;
  logic [LW-1:0] wr_line;
  logic [BW-1:0] rd_beats [NB];
  logic [BW-1:0] wr_exp   [7];
  int            wr_pat   [7];

  initial begin
    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    rd_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wr_line  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wr_pat   = '{1, 0, 0, 1, 1, 0, 1};
    wr_exp   = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD,
                 64'hDDDD_DDDD_DDDD_DDDD};

    // reset, then idle with stray acks
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      resp_i = ~resp_i;
      tick();
    end
    resp_i = 1'b0;
    chk("idle_line", line_o, '0);
    chk("idle_read", LW'(read_o), '0);

    // read of an unaligned address
    read_i = 1'b1; address_i = 32'h1234_567F;
    tick();
    chk("rd_addr", LW'(address_o), LW'(32'h1234_5660));
    chk("rd_req",  LW'(read_o), LW'(1'b1));
    for (int i = 0; i < NB; i++) begin
      resp_i = 1'b1; burst_i = rd_beats[i];
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0;
    chk("rd_resp", LW'(resp_o), LW'(1'b1));
    chk("rd_line", line_o, rd_line);
    chk("rd_drop", LW'(read_o), '0);
    tick();
    chk("rd_resp_once", LW'(resp_o), '0);
    chk("rd_line_hold", line_o, rd_line);

    // stalled write; line_i/address_i change after accept
    write_i = 1'b1; line_i = wr_line; address_i = 32'h8000_0020;
    tick();
    line_i = '1; address_i = 32'h0BAD_0000;
    chk("wr_addr", LW'(address_o), LW'(32'h8000_0020));
    for (int i = 0; i < 7; i++) begin
      chk("wr_beat", LW'(burst_o), LW'(wr_exp[i]));
      resp_i = wr_pat[i][0];
      tick();
    end
    resp_i = 1'b0; write_i = 1'b0;
    chk("wr_resp", LW'(resp_o), LW'(1'b1));
    chk("wr_line_kept", line_o, rd_line);
    tick();

    // simultaneous request: write first, held read afterwards
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_1047;
    line_i = {4{64'h0123_4567_89AB_CDEF}};
    tick();
    chk("sim_write", LW'(write_o), LW'(1'b1));
    chk("sim_noread", LW'(read_o), '0);
    resp_i = 1'b1;
    repeat (NB) tick();
    resp_i = 1'b0; write_i = 1'b0;
    chk("sim_resp", LW'(resp_o), LW'(1'b1));
    tick();
    chk("sim_idle", LW'(read_o), '0);
    tick();
    chk("sim_read", LW'(read_o), LW'(1'b1));
    chk("sim_raddr", LW'(address_o), LW'(32'h0000_1040));
    for (int i = 0; i < NB; i++) begin
      resp_i = 1'b1; burst_i = 64'hA5A5_0000_0000_0000 | 64'(i);
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0;
    chk("sim_rline", line_o, {64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0002,
                              64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0000});
    tick();

    // reset in the middle of a read
    read_i = 1'b1; address_i = 32'h2000_0000;
    tick();
    resp_i = 1'b1; burst_i = 64'hFEED_0000_0000_0001;
    repeat (2) tick();
    resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mrst_read", LW'(read_o), '0);
    chk("mrst_resp", LW'(resp_o), '0);
    chk("mrst_line", line_o, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("mrst_reread", LW'(read_o), LW'(1'b1));
    for (int i = 0; i < NB; i++) begin
      resp_i = 1'b1; burst_i = 64'h5000_0000_0000_0000 | 64'(i);
      tick();
      if (i == NB - 2) chk("mrst_not_early", LW'(resp_o), '0);
    end
    resp_i = 1'b0; read_i = 1'b0;
    chk("mrst_resp_full", LW'(resp_o), LW'(1'b1));
    tick();

    // write request arriving during a read is ignored until IDLE
    read_i = 1'b1; address_i = 32'h0000_4000;
    tick();
    write_i = 1'b1; address_i = 32'hFFFF_FFE0; line_i = {4{64'h7777_0000_7777_0000}};
    repeat (2) tick();
    chk("ign_addr", LW'(address_o), LW'(32'h0000_4000));
    chk("ign_nowr", LW'(write_o), '0);
    resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
    repeat (NB) tick();
    resp_i = 1'b0; read_i = 1'b0;
    chk("ign_resp", LW'(resp_o), LW'(1'b1));
    tick();
    chk("ign_idle", LW'(write_o), '0);
    tick();
    chk("ign_write", LW'(write_o), LW'(1'b1));
    chk("ign_waddr", LW'(address_o), LW'(32'hFFFF_FFE0));
    resp_i = 1'b1;
    repeat (NB) tick();
    resp_i = 1'b0; write_i = 1'b0;
    chk("ign_wresp", LW'(resp_o), LW'(1'b1));
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
